// File: rtl/tv80_mcycle_seq.sv
`default_nettype none
// ============================================================================
// Module  : tv80_mcycle_seq
// Purpose : Machine-cycle / T-state sequencer feeding the TV80 microcode
//           decoder; owns instruction boundaries, prefixes, HALT and bus grant.
// Revision: 1.0 - initial release
// ============================================================================
module tv80_mcycle_seq #(
  parameter int MAX_T = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cen,
  input  logic       wait_n,
  input  logic [2:0] mcycles,
  input  logic [2:0] tstates,
  input  logic [1:0] prefix,
  input  logic       halt,
  input  logic       int_req,
  input  logic       busrq_n,
  output logic [6:0] mcycle,
  output logic [6:0] tstate,
  output logic [1:0] iset,
  output logic       xy_mode,
  output logic       m1_n,
  output logic       ir_load,
  output logic       instr_done,
  output logic       int_cycle,
  output logic       halt_n,
  output logic       busak_n
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_HALTED   = 2'd1,
    ST_BUSGRANT = 2'd2
  } state_t;

  localparam logic [2:0] c_max_t = 3'(MAX_T);

  state_t     fsm_q, fsm_d, ret_q, ret_d, nxt_state;
  logic       pend_int_q, pend_int_d, nxt_int;
  logic [6:0] mcycle_q, mcycle_d, tstate_q, tstate_d;
  logic [1:0] iset_q, iset_d;
  logic       xy_mode_q, xy_mode_d;
  logic       int_cycle_q, int_cycle_d;
  logic       halt_n_q, halt_n_d;
  logic       busak_n_q, busak_n_d;

  logic [2:0] t_idx, m_idx, t_clamp, eff_t, eff_m, t_lim;
  logic       t_end, m_last;

  always_comb begin
    t_idx = 3'd0;
    m_idx = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (tstate_q[i]) t_idx = 3'(i + 1);
      if (mcycle_q[i]) m_idx = 3'(i + 1);
    end
  end

  // The HALT loop is a fixed 4T opcode fetch regardless of what the decoder says.
  assign t_clamp = (tstates > c_max_t) ? c_max_t : tstates;
  assign eff_t   = (t_clamp < 3'd3) ? 3'd3 : t_clamp;
  assign eff_m   = (mcycles == 3'd0) ? 3'd1 : mcycles;
  assign t_lim   = (fsm_q == ST_HALTED) ? 3'd4 : eff_t;
  assign t_end   = (t_idx >= t_lim);
  assign m_last  = (m_idx >= eff_m);

  always_comb begin
    fsm_d       = fsm_q;
    ret_d       = ret_q;
    pend_int_d  = pend_int_q;
    mcycle_d    = mcycle_q;
    tstate_d    = tstate_q;
    iset_d      = iset_q;
    xy_mode_d   = xy_mode_q;
    int_cycle_d = int_cycle_q;
    halt_n_d    = halt_n_q;
    busak_n_d   = busak_n_q;
    nxt_state   = fsm_q;
    nxt_int     = int_cycle_q;
    ir_load     = 1'b0;
    instr_done  = 1'b0;

    if (cen) begin
      case (fsm_q)
        ST_RUN, ST_HALTED: begin
          if (t_end) begin
            tstate_d = 7'b0000001;
            if (fsm_q == ST_HALTED) begin
              instr_done = 1'b1;
              if (int_req) begin
                nxt_state = ST_RUN;
                nxt_int   = 1'b1;
              end
            end else if (m_last) begin
              instr_done = 1'b1;
              mcycle_d   = 7'b0000001;
              case (prefix)
                2'b01:   iset_d = 2'b01;
                2'b10: begin
                  iset_d    = 2'b10;
                  xy_mode_d = 1'b0;
                end
                2'b11: begin
                  iset_d    = 2'b00;
                  xy_mode_d = 1'b1;
                end
                default: begin
                  iset_d    = 2'b00;
                  xy_mode_d = 1'b0;
                end
              endcase
              nxt_int = (prefix == 2'b00) && int_req;
              if ((prefix == 2'b00) && halt && !int_req) nxt_state = ST_HALTED;
            end else begin
              mcycle_d = mcycle_q << 1;
            end
            // A bus grant defers the int/halt decision until release.
            if (!busrq_n) begin
              fsm_d      = ST_BUSGRANT;
              ret_d      = nxt_state;
              pend_int_d = nxt_int;
              busak_n_d  = 1'b0;
            end else begin
              fsm_d       = nxt_state;
              int_cycle_d = nxt_int;
              halt_n_d    = (nxt_state != ST_HALTED);
            end
          end else if (tstate_q[1] && !wait_n) begin
            tstate_d = tstate_q;
          end else begin
            tstate_d = tstate_q << 1;
            if (tstate_q[1] && mcycle_q[0] && (fsm_q == ST_RUN)) ir_load = 1'b1;
          end
        end
        ST_BUSGRANT: begin
          if (busrq_n) begin
            fsm_d       = ret_q;
            busak_n_d   = 1'b1;
            int_cycle_d = pend_int_q;
            halt_n_d    = (ret_q != ST_HALTED);
          end
        end
        default: fsm_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q       <= ST_RUN;
      ret_q       <= ST_RUN;
      pend_int_q  <= 1'b0;
      mcycle_q    <= 7'b0000001;
      tstate_q    <= 7'b0000001;
      iset_q      <= 2'b00;
      xy_mode_q   <= 1'b0;
      int_cycle_q <= 1'b0;
      halt_n_q    <= 1'b1;
      busak_n_q   <= 1'b1;
    end else begin
      fsm_q       <= fsm_d;
      ret_q       <= ret_d;
      pend_int_q  <= pend_int_d;
      mcycle_q    <= mcycle_d;
      tstate_q    <= tstate_d;
      iset_q      <= iset_d;
      xy_mode_q   <= xy_mode_d;
      int_cycle_q <= int_cycle_d;
      halt_n_q    <= halt_n_d;
      busak_n_q   <= busak_n_d;
    end
  end

  assign mcycle    = mcycle_q;
  assign tstate    = tstate_q;
  assign iset      = iset_q;
  assign xy_mode   = xy_mode_q;
  assign int_cycle = int_cycle_q;
  assign halt_n    = halt_n_q;
  assign busak_n   = busak_n_q;
  assign m1_n      = (fsm_q == ST_BUSGRANT) ? 1'b1 : ~mcycle_q[0];

endmodule
`default_nettype wire

// File: tb/tb_tv80_mcycle_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_tv80_mcycle_seq
// Purpose : Directed and randomized checking of tv80_mcycle_seq against an
//           integer-level model of the sequencing rules.
// Revision: 1.0 - initial release
// ============================================================================
module tb_tv80_mcycle_seq;
  localparam int MAX_T = 6;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       cen = 1'b1, wait_n = 1'b1, halt = 1'b0, int_req = 1'b0, busrq_n = 1'b1;
  logic [2:0] mcycles = 3'd1, tstates = 3'd4;
  logic [1:0] prefix = 2'b00;
  logic [6:0] mcycle, tstate;
  logic [1:0] iset;
  logic       xy_mode, m1_n, ir_load, instr_done, int_cycle, halt_n, busak_n;

  tv80_mcycle_seq #(.MAX_T(MAX_T)) dut (
    .clk(clk), .reset_n(reset_n), .cen(cen), .wait_n(wait_n),
    .mcycles(mcycles), .tstates(tstates), .prefix(prefix), .halt(halt),
    .int_req(int_req), .busrq_n(busrq_n), .mcycle(mcycle), .tstate(tstate),
    .iset(iset), .xy_mode(xy_mode), .m1_n(m1_n), .ir_load(ir_load),
    .instr_done(instr_done), .int_cycle(int_cycle), .halt_n(halt_n), .busak_n(busak_n)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: integer M/T indices; mode 0=running, 1=halted, 2=bus granted.
  int mm = 1, tt = 1, mode = 0, ret_mode = 0, pend_int = 0;
  int iset_m = 0, xy_m = 0, intc_m = 0, haltn_m = 1, busak_m = 1;

  function automatic int t_limit();
    int x;
    if (mode == 1) return 4;
    x = int'(tstates);
    if (x > MAX_T) x = MAX_T;
    if (x < 3) x = 3;
    return x;
  endfunction

  function automatic bit last_m();
    return mm >= ((mcycles == 3'd0) ? 1 : int'(mcycles));
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mm = 1; tt = 1; mode = 0; ret_mode = 0; pend_int = 0;
      iset_m = 0; xy_m = 0; intc_m = 0; haltn_m = 1; busak_m = 1;
    end else if (cen) begin
      if (mode == 2) begin
        if (busrq_n) begin
          mode = ret_mode; busak_m = 1; intc_m = pend_int; haltn_m = (ret_mode == 1) ? 0 : 1;
        end
      end else if (tt < t_limit()) begin
        if (!(tt == 2 && !wait_n)) tt++;
      end else begin
        int nmode, nint;
        nmode = mode; nint = intc_m; tt = 1;
        if (mode == 1) begin
          if (int_req) begin nmode = 0; nint = 1; end
        end else if (last_m()) begin
          mm = 1;
          if (prefix == 2'b01) iset_m = 1;
          else if (prefix == 2'b10) begin iset_m = 2; xy_m = 0; end
          else if (prefix == 2'b11) begin iset_m = 0; xy_m = 1; end
          else begin iset_m = 0; xy_m = 0; end
          nint = (prefix == 2'b00 && int_req) ? 1 : 0;
          if (prefix == 2'b00 && halt && !int_req) nmode = 1;
        end else mm++;
        if (!busrq_n) begin
          ret_mode = nmode; pend_int = nint; mode = 2; busak_m = 0;
        end else begin
          mode = nmode; intc_m = nint; haltn_m = (nmode == 1) ? 0 : 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit e_ir, e_done;
      e_ir   = cen && mode == 0 && mm == 1 && tt == 2 && wait_n;
      e_done = cen && mode != 2 && tt >= t_limit() && (mode == 1 || last_m());
      chk("mcycle", int'(mcycle), 1 << (mm - 1));
      chk("tstate", int'(tstate), 1 << (tt - 1));
      chk("iset", int'(iset), iset_m);
      chk("xy_mode", int'(xy_mode), xy_m);
      chk("m1_n", int'(m1_n), (mode == 2 || mm != 1) ? 1 : 0);
      chk("ir_load", int'(ir_load), int'(e_ir));
      chk("instr_done", int'(instr_done), int'(e_done));
      chk("int_cycle", int'(int_cycle), intc_m);
      chk("halt_n", int'(halt_n), haltn_m);
      chk("busak_n", int'(busak_n), busak_m);
    end
  end

  // Decoder emulation for directed tests: first M-cycle length, then the rest.
  bit dec_on = 1'b0;
  int dec_t1 = 4, dec_tr = 4;

  task automatic drive_dec();
    if (dec_on) tstates = 3'((mm == 1) ? dec_t1 : dec_tr);
  endtask

  task automatic set_dec(input int mc, input int t1, input int tr, input int pf, input bit h);
    dec_on = 1'b1; mcycles = 3'(mc); dec_t1 = t1; dec_tr = tr; prefix = 2'(pf); halt = h;
    drive_dec();
  endtask

  task automatic cyc(output bit done, output bit irl);
    @(negedge clk);
    done = instr_done;
    irl  = ir_load;
    @(posedge clk);
    #2;
    drive_dec();
  endtask

  task automatic run_instr(output int n, output int ir_at, output int ir_cnt);
    bit done, irl;
    n = 0; ir_at = 0; ir_cnt = 0; done = 1'b0;
    while (!done && n < 50) begin
      cyc(done, irl);
      n++;
      if (irl) begin ir_cnt++; if (ir_at == 0) ir_at = n; end
    end
    if (!done) chk("instr_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset_n = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b1;
    drive_dec();
  endtask

  initial begin
    int n, ir_at, ir_cnt;
    bit done, irl;
    #1 reset_n = 1'b0;
    #1 chk_en = 1'b1;
    chk("rst_mcycle", int'(mcycle), 1);
    chk("rst_tstate", int'(tstate), 1);
    chk("rst_m1_n", int'(m1_n), 0);
    chk("rst_halt_n", int'(halt_n), 1);
    chk("rst_busak_n", int'(busak_n), 1);
    @(posedge clk); #2;
    reset_n = 1'b1;

    set_dec(1, 4, 4, 0, 0);
    run_instr(n, ir_at, ir_cnt);
    chk("nop_len", n, 4);
    chk("nop_ir_at", ir_at, 2);
    chk("nop_mcycle", int'(mcycle), 1);

    set_dec(3, 4, 3, 0, 0);
    run_instr(n, ir_at, ir_cnt);
    chk("op3_len", n, 10);

    set_dec(1, 4, 4, 0, 0);
    n = 0; ir_at = 0; ir_cnt = 0; done = 1'b0;
    while (!done && n < 20) begin
      wait_n = (n >= 1 && n <= 3) ? 1'b0 : 1'b1;
      cyc(done, irl);
      n++;
      if (irl) begin ir_cnt++; ir_at = n; end
    end
    wait_n = 1'b1;
    chk("wait_len", n, 7);
    chk("wait_ir_cnt", ir_cnt, 1);
    chk("wait_ir_at", ir_at, 5);

    set_dec(1, 4, 4, 3, 0);
    run_instr(n, ir_at, ir_cnt);
    chk("dd_iset", int'(iset), 0);
    chk("dd_xy", int'(xy_mode), 1);
    set_dec(1, 4, 4, 1, 0);
    run_instr(n, ir_at, ir_cnt);
    chk("cb_iset", int'(iset), 1);
    chk("cb_xy", int'(xy_mode), 1);
    set_dec(1, 4, 4, 0, 0);
    run_instr(n, ir_at, ir_cnt);
    chk("plain_iset", int'(iset), 0);
    chk("plain_xy", int'(xy_mode), 0);

    set_dec(1, 4, 4, 0, 1);
    run_instr(n, ir_at, ir_cnt);
    chk("halt_n_low", int'(halt_n), 0);
    set_dec(2, 5, 5, 0, 0);
    run_instr(n, ir_at, ir_cnt);
    chk("halt_loop_len", n, 4);
    chk("halt_loop_ir", ir_cnt, 0);
    n = 0; done = 1'b0;
    while (!done && n < 20) begin
      int_req = (n >= 1) ? 1'b1 : 1'b0;
      cyc(done, irl);
      n++;
    end
    int_req = 1'b0;
    chk("halt_exit_len", n, 4);
    chk("halt_exit_halt_n", int'(halt_n), 1);
    chk("halt_exit_intc", int'(int_cycle), 1);
    chk("halt_exit_mcycle", int'(mcycle), 1);
    set_dec(1, 4, 4, 0, 0);
    run_instr(n, ir_at, ir_cnt);
    chk("intc_cleared", int'(int_cycle), 0);

    set_dec(3, 4, 3, 0, 0);
    for (int k = 1; k <= 7; k++) begin
      busrq_n = (k >= 6) ? 1'b0 : 1'b1;
      cyc(done, irl);
    end
    chk("grant_busak", int'(busak_n), 0);
    chk("grant_mcycle", int'(mcycle), 4);
    for (int k = 0; k < 3; k++) cyc(done, irl);
    chk("grant_hold_mcycle", int'(mcycle), 4);
    chk("grant_hold_tstate", int'(tstate), 1);
    chk("grant_m1_n", int'(m1_n), 1);
    busrq_n = 1'b1;
    cyc(done, irl);
    chk("release_busak", int'(busak_n), 1);
    chk("release_tstate", int'(tstate), 1);
    run_instr(n, ir_at, ir_cnt);
    chk("release_m3_len", n, 3);

    set_dec(1, 4, 4, 3, 0);
    busrq_n = 1'b0;
    run_instr(n, ir_at, ir_cnt);
    cyc(done, irl);
    chk("grant2_busak", int'(busak_n), 0);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_busak", int'(busak_n), 1);
    chk("arst_xy", int'(xy_mode), 0);
    chk("arst_m1_n", int'(m1_n), 0);
    chk("arst_tstate", int'(tstate), 1);
    busrq_n = 1'b1;
    @(posedge clk); #2;
    reset_n = 1'b1;

    dec_on = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      cen     = ($urandom_range(0, 7) != 0);
      wait_n  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) mcycles = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) tstates = 3'($urandom_range(0, 7));
      prefix  = 2'($urandom_range(0, 3));
      halt    = ($urandom_range(0, 5) == 0);
      int_req = ($urandom_range(0, 7) == 0);
      busrq_n = ($urandom_range(0, 9) != 0);
      if (c % 700 == 699) do_reset();
      @(posedge clk); #2;
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
